// File: rtl/design_ip_arbiter_if.sv
// Bus between the arbiter (master side) and the design_ip slave port.
// rdata is valid in the cycle after sel.
interface design_ip_arbiter_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 64
);
    logic [BUS_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write;
    logic                  sel;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output addr, wdata, write, sel, input rdata);
    modport slave  (input addr, wdata, write, sel, output rdata);
endinterface

// File: rtl/design_ip_arbiter.sv
// Round-robin arbiter with bounded bursts that shares one design_ip port between
// NUM_REQ requesters. Each access is a one-cycle sel strobe; reads return data to the owner.
module design_ip_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    design_ip_arbiter_if.master           ip
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [IDX_W-1:0] rr_win;
    logic [IDX_W-1:0] winner;
    logic             burst_cont;
    int               pos;

    // rr_ptr is where the next search starts (last owner + 1); walking the
    // offsets downward lets the nearest requester after the pointer win.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rr_win = rr_ptr;
        pos    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (req[pos]) rr_win = IDX_W'(pos);
        end
    end

    assign burst_cont = req[owner] && (burst_cnt != '0) && (burst_cnt < BURST_MAX);
    assign winner     = burst_cont ? owner : rr_win;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            ip.addr   <= '0;
            ip.wdata  <= '0;
            ip.write  <= 1'b0;
            ip.sel    <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            ip.sel    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner       <= winner;
                        rr_ptr      <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
                        burst_cnt   <= burst_cont ? burst_cnt + CNT_W'(1) : CNT_W'(1);
                        ip.addr     <= req_addr[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
                        ip.wdata    <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        ip.write    <= req_write[winner];
                        ip.sel      <= 1'b1;
                        gnt[winner] <= 1'b1;
                        state       <= ACCESS;
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                ACCESS: state <= ip.write ? IDLE : RESP;
                RESP: begin
                    // design_ip drives rdata in this cycle; the owner sees it one cycle later.
                    rsp_rdata        <= ip.rdata;
                    rsp_valid[owner] <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_design_ip_arbiter.sv
// Scoreboard bench for design_ip_arbiter: expected grants/responses are queued when
// requests are launched and compared as the arbiter issues them.
module tb_design_ip_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int BUS_WIDTH  = 32;
    localparam int DATA_WIDTH = 64;
    localparam int MAX_BURST  = 4;
    localparam int SEQ_ALL [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};

    typedef struct {
        logic [NUM_REQ-1:0]    vec;
        logic [BUS_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  write;
    } gnt_exp_t;

    typedef struct {
        logic [NUM_REQ-1:0]    vec;
        logic [DATA_WIDTH-1:0] data;
    } rsp_exp_t;

    logic                          clk = 1'b0;
    logic                          rstn;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*BUS_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    design_ip_arbiter_if #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) ip_bus ();

    design_ip_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .BUS_WIDTH (BUS_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ip       (ip_bus)
    );

    always #5 clk = ~clk;

    int                   n_tests;
    int                   n_fail;
    int                   cyc;
    int                   last_gnt_cyc;
    int                   gap_exp;
    bit                   in_reset;
    int                   cnt   [NUM_REQ];
    int                   act_k [NUM_REQ];
    int                   exp_k [NUM_REQ];
    bit                   wr    [NUM_REQ];
    logic [BUS_WIDTH-1:0] base  [NUM_REQ];
    gnt_exp_t             gnt_q [$];
    rsp_exp_t             rsp_q [$];

    function automatic logic [DATA_WIDTH-1:0] rd_fn(input logic [BUS_WIDTH-1:0] a);
        if (a == 32'h10) return 64'hCAFE;
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    function automatic logic [BUS_WIDTH-1:0] addr_fn(input int i, input int k);
        return base[i] + BUS_WIDTH'(8 * k);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wdata_fn(input int i, input int k);
        return {8'(i + 1), 24'h5A5A5A, 32'(k)};
    endfunction

    // design_ip slave model: read data appears in the cycle after sel.
    always @(posedge clk)
        ip_bus.rdata <= (ip_bus.sel && !ip_bus.write) ? rd_fn(ip_bus.addr) : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]       = (cnt[i] != 0);
            req_write[i] = wr[i];
            req_addr[i*BUS_WIDTH +: BUS_WIDTH]    = addr_fn(i, act_k[i]);
            req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata_fn(i, act_k[i]);
        end
    endtask

    task automatic start(input int i, input int n, input bit w);
        cnt[i] = n;
        wr[i]  = w;
        update_drive();
    endtask

    task automatic push_gnt(input int i, input bit w, input bit with_rsp);
        gnt_exp_t ge;
        rsp_exp_t re;
        ge.vec    = '0;
        ge.vec[i] = 1'b1;
        ge.addr   = addr_fn(i, exp_k[i]);
        ge.wdata  = wdata_fn(i, exp_k[i]);
        ge.write  = w;
        gnt_q.push_back(ge);
        if (!w && with_rsp) begin
            re.vec  = ge.vec;
            re.data = rd_fn(ge.addr);
            rsp_q.push_back(re);
        end
        exp_k[i]++;
    endtask

    // One cycle: sample at negedge, score outputs, then let requesters react to gnt.
    task automatic step();
        gnt_exp_t ge;
        rsp_exp_t re;
        @(negedge clk);
        cyc++;
        if (!in_reset) begin
            check("sel_eq_gnt", 64'(ip_bus.sel), 64'(|gnt));
            check("gnt_rsp_excl", 64'((|gnt) && (|rsp_valid)), '0);
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'(gnt), '0);
                end else begin
                    ge = gnt_q.pop_front();
                    check("gnt", 64'(gnt), 64'(ge.vec));
                    check("ip_addr", 64'(ip_bus.addr), 64'(ge.addr));
                    check("ip_write", 64'(ip_bus.write), 64'(ge.write));
                    check("ip_wdata", 64'(ip_bus.wdata), 64'(ge.wdata));
                    if (gap_exp != 0 && last_gnt_cyc >= 0)
                        check("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(gap_exp));
                end
                last_gnt_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), '0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(re.vec));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(re.data));
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && cnt[i] > 0) begin
                cnt[i]--;
                act_k[i]++;
            end
        end
        update_drive();
    endtask

    task automatic check_outputs_zero();
        check("zero_gnt", 64'(gnt), '0);
        check("zero_rsp_valid", 64'(rsp_valid), '0);
        check("zero_rsp_rdata", 64'(rsp_rdata), '0);
        check("zero_ip_addr", 64'(ip_bus.addr), '0);
        check("zero_ip_wdata", 64'(ip_bus.wdata), '0);
        check("zero_ip_write", 64'(ip_bus.write), '0);
        check("zero_ip_sel", 64'(ip_bus.sel), '0);
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        in_reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i]   = 0;
            act_k[i] = 0;
            exp_k[i] = 0;
            wr[i]    = 1'b0;
            base[i]  = BUS_WIDTH'(32'h100 * (i + 1));
        end
        update_drive();
        gnt_q.delete();
        rsp_q.delete();
        step();
        step();
        check_outputs_zero();
        rstn         = 1'b1;
        in_reset     = 1'b0;
        last_gnt_cyc = -1;
        gap_exp      = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((gnt_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_gnt_left", 64'(gnt_q.size()), '0);
        check("drain_rsp_left", 64'(rsp_q.size()), '0);
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        // Reset state, then a quiet bus for 20 cycles.
        do_reset();
        repeat (20) begin
            step();
            check("idle_gnt", 64'(gnt), '0);
            check("idle_sel", 64'(ip_bus.sel), '0);
            check("idle_rsp", 64'(rsp_valid), '0);
        end

        // Single read from requester 0 with exact latency.
        base[0] = 32'h10;
        push_gnt(0, 1'b0, 1'b1);
        start(0, 1, 1'b0);
        step();
        check("t1_gnt", 64'(gnt), 64'(4'b0001));
        check("t1_sel", 64'(ip_bus.sel), 64'(1));
        check("t1_write", 64'(ip_bus.write), '0);
        check("t1_addr", 64'(ip_bus.addr), 64'(32'h10));
        step();
        check("t1_rsp_early", 64'(rsp_valid), '0);
        step();
        check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("t1_rsp_rdata", 64'(rsp_rdata), 64'hCAFE);
        drain(10);

        // All four hold req with writes: bursts of MAX_BURST in round-robin order.
        do_reset();
        gap_exp = 2;
        foreach (SEQ_ALL[j]) push_gnt(SEQ_ALL[j], 1'b1, 1'b1);
        start(0, 5, 1'b1);
        start(1, 4, 1'b1);
        start(2, 4, 1'b1);
        start(3, 4, 1'b1);
        drain(100);

        // One access each, mixed reads and writes, then the bus goes quiet.
        do_reset();
        push_gnt(0, 1'b1, 1'b1);
        push_gnt(1, 1'b0, 1'b1);
        push_gnt(2, 1'b1, 1'b1);
        push_gnt(3, 1'b0, 1'b1);
        start(0, 1, 1'b1);
        start(1, 1, 1'b0);
        start(2, 1, 1'b1);
        start(3, 1, 1'b0);
        drain(50);
        repeat (5) begin
            step();
            check("t3_quiet_sel", 64'(ip_bus.sel), '0);
            check("t3_quiet_gnt", 64'(gnt), '0);
        end

        // Lone requester 2: burst counter restarts after MAX_BURST with no gap.
        do_reset();
        gap_exp = 2;
        repeat (6) push_gnt(2, 1'b1, 1'b1);
        start(2, 6, 1'b1);
        drain(50);

        // Reset during the RESP cycle of a requester-1 read.
        do_reset();
        push_gnt(1, 1'b0, 1'b0);
        start(1, 1, 1'b0);
        step();
        check("t5_gnt", 64'(gnt), 64'(4'b0010));
        step();
        rstn     = 1'b0;
        in_reset = 1'b1;
        step();
        check_outputs_zero();
        rstn     = 1'b1;
        in_reset = 1'b0;
        step();
        check("t5_no_rsp", 64'(rsp_valid), '0);
        last_gnt_cyc = -1;
        gap_exp      = 2;
        push_gnt(1, 1'b1, 1'b1);
        push_gnt(3, 1'b1, 1'b1);
        start(1, 1, 1'b1);
        start(3, 1, 1'b1);
        drain(50);

        // Back-to-back read bursts from requesters 1 and 3.
        do_reset();
        gap_exp = 3;
        push_gnt(1, 1'b0, 1'b1);
        push_gnt(1, 1'b0, 1'b1);
        push_gnt(3, 1'b0, 1'b1);
        push_gnt(3, 1'b0, 1'b1);
        start(1, 2, 1'b0);
        start(3, 2, 1'b0);
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
